// File: rtl/pio_in_edge_irq_multi.sv
// Parametrised input PIO with Avalon-MM slave access for the NIOS2 CPU.
// Synchronises WIDTH asynchronous inputs, debounces each bit against a
// programmable threshold, detects rising/falling edges per bit into a
// write-1-to-clear capture register and raises a masked level interrupt.
//
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   address        word address of the register being accessed
//   chipselect     slave select (qualifies writes only)
//   write_n        active-low write strobe
//   writedata      write data, bits above the register width ignored
//   in_port        asynchronous external inputs
//   readdata       registered read data, one cycle after address
//   irq            level interrupt, OR of masked capture flags
//
// Register map: 0 DATA(RO) 1 RISE_EN 2 IRQ_MASK 3 CAPTURE(W1C) 4 FALL_EN
//               5 DB_CNT, 6/7 read as zero.
module pio_in_edge_irq_multi #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned CW = DB_W + 1;

    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_RISE  = 3'd1;
    localparam logic [2:0] ADDR_MASK  = 3'd2;
    localparam logic [2:0] ADDR_CAP   = 3'd3;
    localparam logic [2:0] ADDR_FALL  = 3'd4;
    localparam logic [2:0] ADDR_DBCNT = 3'd5;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  deb_q, deb_d;
    logic [WIDTH-1:0]                  deb_dly_q, deb_dly_d;
    logic [WIDTH-1:0][DB_W-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]                  rise_en_q, rise_en_d;
    logic [WIDTH-1:0]                  fall_en_q, fall_en_d;
    logic [WIDTH-1:0]                  mask_q, mask_d;
    logic [WIDTH-1:0]                  cap_q, cap_d;
    logic [DB_W-1:0]                   db_n_q, db_n_d;
    logic [31:0]                       readdata_q, readdata_d;

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] clr;
    logic [DB_W-1:0]  thr;
    logic             wr;
    logic             unused_wdata;

    // Only the low bits of writedata reach a register; the reduction marks the rest as intentionally dropped.
    assign unused_wdata = ^writedata;

    // Next-state logic for all registers.
    always_comb begin
        sync_d     = sync_q;
        deb_d      = deb_q;
        deb_dly_d  = deb_q;
        cnt_d      = cnt_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        mask_d     = mask_q;
        db_n_d     = db_n_q;
        readdata_d = 32'd0;
        clr        = '0;

        wr = chipselect & ~write_n;
        s  = sync_q[SYNC_STAGES-1];

        // Synchroniser shift chain, stage 0 samples the pins.
        sync_d = {sync_q[SYNC_STAGES-2:0], in_port};

        // A threshold of 0 behaves like 1: deb follows s after one cycle of disagreement.
        thr = (db_n_q == '0) ? DB_W'(1) : db_n_q;

        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if ((CW'(cnt_q[i]) + CW'(1)) >= CW'(thr)) begin
                deb_d[i] = s[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DB_W'(1);
            end
        end

        rise = deb_q & ~deb_dly_q & rise_en_q;
        fall = ~deb_q & deb_dly_q & fall_en_q;

        if (wr) begin
            case (address)
                ADDR_RISE:  rise_en_d = writedata[WIDTH-1:0];
                ADDR_MASK:  mask_d    = writedata[WIDTH-1:0];
                ADDR_CAP:   clr       = writedata[WIDTH-1:0];
                ADDR_FALL:  fall_en_d = writedata[WIDTH-1:0];
                ADDR_DBCNT: begin
                    db_n_d = writedata[DB_W-1:0];
                    cnt_d  = '0;
                end
                default: ;
            endcase
        end

        // New edges take priority over a coincident clear so no edge is lost.
        cap_d = (cap_q & ~clr) | rise | fall;

        case (address)
            ADDR_DATA:  readdata_d = 32'(deb_q);
            ADDR_RISE:  readdata_d = 32'(rise_en_q);
            ADDR_MASK:  readdata_d = 32'(mask_q);
            ADDR_CAP:   readdata_d = 32'(cap_q);
            ADDR_FALL:  readdata_d = 32'(fall_en_q);
            ADDR_DBCNT: readdata_d = 32'(db_n_q);
            default:    readdata_d = 32'd0;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            deb_q      <= '0;
            deb_dly_q  <= '0;
            cnt_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            db_n_q     <= '0;
            readdata_q <= 32'd0;
        end else begin
            sync_q     <= sync_d;
            deb_q      <= deb_d;
            deb_dly_q  <= deb_dly_d;
            cnt_q      <= cnt_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            db_n_q     <= db_n_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    // Level interrupt derived directly from flopped capture and mask state.
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_in_edge_irq_multi.sv
module tb_pio_in_edge_irq_multi;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned DB_W  = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [2:0]       address = 3'd0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = 32'd0;
    logic [WIDTH-1:0] in_port = '0;
    logic [31:0]      readdata;
    logic             irq;

    int errors = 0;
    int checks = 0;

    pio_in_edge_irq_multi #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DB_W(DB_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Behavioural reference: pin history, per-bit disagreement run lengths, register file.
    logic [7:0]  m_hist [SYNC];
    int          m_run  [8];
    logic [7:0]  m_deb = '0, m_deb_prev = '0, m_rise = '0, m_fall = '0;
    logic [7:0]  m_mask = '0, m_cap = '0;
    logic [15:0] m_n = '0;
    logic [31:0] m_rd = '0;
    logic [7:0]  ms, mnd, mclr, medge;
    int          mthr;

    initial begin
        for (int j = 0; j < SYNC; j++) m_hist[j] = '0;
        for (int j = 0; j < 8; j++) m_run[j] = 0;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < SYNC; j++) m_hist[j] = '0;
            for (int j = 0; j < 8; j++) m_run[j] = 0;
            m_deb = '0; m_deb_prev = '0; m_rise = '0; m_fall = '0;
            m_mask = '0; m_cap = '0; m_n = '0; m_rd = '0;
        end else begin
            case (address)
                3'd0: m_rd = {24'd0, m_deb};
                3'd1: m_rd = {24'd0, m_rise};
                3'd2: m_rd = {24'd0, m_mask};
                3'd3: m_rd = {24'd0, m_cap};
                3'd4: m_rd = {24'd0, m_fall};
                3'd5: m_rd = {16'd0, m_n};
                default: m_rd = 32'd0;
            endcase
            ms    = m_hist[SYNC-1];
            medge = (m_deb & ~m_deb_prev & m_rise) | (~m_deb & m_deb_prev & m_fall);
            mclr  = (chipselect && !write_n && address == 3'd3) ? writedata[7:0] : 8'd0;
            mthr  = (m_n == 16'd0) ? 1 : int'(m_n);
            mnd   = m_deb;
            for (int j = 0; j < 8; j++) begin
                if (ms[j] == m_deb[j]) m_run[j] = 0;
                else if (m_run[j] + 1 >= mthr) begin
                    mnd[j] = ms[j];
                    m_run[j] = 0;
                end else m_run[j] = m_run[j] + 1;
            end
            m_deb_prev = m_deb;
            m_deb      = mnd;
            m_cap      = (m_cap & ~mclr) | medge;
            if (chipselect && !write_n) begin
                case (address)
                    3'd1: m_rise = writedata[7:0];
                    3'd2: m_mask = writedata[7:0];
                    3'd4: m_fall = writedata[7:0];
                    3'd5: begin
                        m_n = writedata[15:0];
                        for (int j = 0; j < 8; j++) m_run[j] = 0;
                    end
                    default: ;
                endcase
            end
            for (int j = SYNC - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = in_port;
        end
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic quiesce();
        bus_write(3'd4, 32'd0);
        bus_write(3'd1, 32'd0);
        bus_write(3'd5, 32'd0);
        in_port = '0;
        repeat (8) @(negedge clk);
        bus_write(3'd3, 32'hFF);
        bus_write(3'd2, 32'd0);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        checks++;
        if (irq !== 1'b0 || readdata !== 32'd0) begin
            errors++; $display("FAIL reset_hold: irq=%b readdata=%h required 0/0", irq, readdata);
        end
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), d);
            checks++;
            if (d !== 32'd0) begin
                errors++; $display("FAIL reset_reg%0d: got %h required 0", a, d);
            end
        end
    endtask

    task automatic test_rise_default();
        logic [31:0] d;
        quiesce();
        bus_write(3'd1, 32'h01);
        bus_write(3'd2, 32'h01);
        in_port = 8'h01;
        repeat (3) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL rise_early_irq: got %b required 0", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL rise_irq: got %b required 1", irq);
        end
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h1) begin
            errors++; $display("FAIL rise_capture: got %h required 00000001", d);
        end
    endtask

    task automatic test_w1c();
        logic [31:0] d;
        quiesce();
        bus_write(3'd1, 32'h05);
        in_port = 8'h05;
        repeat (5) @(negedge clk);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h05) begin errors++; $display("FAIL w1c_set: got %h required 05", d); end
        bus_write(3'd3, 32'h04);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h01) begin errors++; $display("FAIL w1c_partial: got %h required 01", d); end
        bus_write(3'd3, 32'h01);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h00) begin errors++; $display("FAIL w1c_clear: got %h required 00", d); end
        in_port = 8'h04;
        repeat (5) @(negedge clk);
        in_port = 8'h05;
        repeat (3) @(negedge clk);
        bus_write(3'd3, 32'h01);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h01) begin errors++; $display("FAIL w1c_collision: got %h required 01", d); end
    endtask

    task automatic test_fall();
        logic [31:0] d;
        quiesce();
        bus_write(3'd1, 32'h80);
        bus_write(3'd4, 32'h80);
        in_port = 8'hC0;
        repeat (5) @(negedge clk);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h80) begin errors++; $display("FAIL fall_rise_set: got %h required 80", d); end
        bus_write(3'd3, 32'h80);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h00) begin errors++; $display("FAIL fall_cleared: got %h required 00", d); end
        repeat (12) @(negedge clk);
        in_port = 8'h00;
        repeat (5) @(negedge clk);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h80) begin errors++; $display("FAIL fall_set: got %h required 80", d); end
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        quiesce();
        bus_write(3'd5, 32'd10);
        bus_write(3'd1, 32'h08);
        bus_write(3'd2, 32'h08);
        in_port = 8'h08;
        repeat (9) @(negedge clk);
        in_port = 8'h00;
        repeat (15) @(negedge clk);
        bus_read(3'd0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL db_glitch_data: got %h required 0", d); end
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL db_glitch_cap: got %h required 0", d); end
        in_port = 8'h08;
        repeat (12) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL db_early_irq: got %b required 0", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL db_irq: got %b required 1", irq); end
        bus_read(3'd0, d);
        checks++;
        if (d !== 32'h08) begin errors++; $display("FAIL db_data: got %h required 08", d); end
        in_port = 8'h00;
        bus_write(3'd5, 32'd0);
    endtask

    task automatic test_mask();
        logic [31:0] d;
        quiesce();
        bus_write(3'd1, 32'h02);
        in_port = 8'h02;
        repeat (5) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL mask_off_irq: got %b required 0", irq); end
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h02) begin errors++; $display("FAIL mask_cap: got %h required 02", d); end
        bus_write(3'd2, 32'h02);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL mask_on_irq: got %b required 1", irq); end
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd6, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL addr6: got %h required 0", d); end
        bus_read(3'd7, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL addr7: got %h required 0", d); end
        bus_write(3'd0, 32'hFF);
        bus_read(3'd0, d);
        checks++;
        if (d !== 32'h02) begin errors++; $display("FAIL data_ro: got %h required 02", d); end
        bus_write(3'd3, 32'h02);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL mask_clear_irq: got %b required 0", irq); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            address = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                chipselect = 1'b1; write_n = 1'b0;
                writedata = (address == 3'd5) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            end else begin
                chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1;
                writedata = 32'($urandom);
            end
            if ($urandom_range(0, 3) == 0)
                in_port = in_port ^ (8'd1 << $urandom_range(0, 7));
            @(negedge clk);
            checks++;
            if (readdata !== m_rd) begin
                errors++; $display("FAIL rand_readdata cycle %0d: got %h required %h", c, readdata, m_rd);
            end
            checks++;
            if (irq !== |(m_cap & m_mask)) begin
                errors++; $display("FAIL rand_irq cycle %0d: got %b required %b", c, irq, |(m_cap & m_mask));
            end
        end
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        quiesce();
        bus_write(3'd5, 32'd10);
        bus_write(3'd1, 32'h01);
        bus_write(3'd2, 32'h01);
        in_port = 8'h01;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0 || readdata !== 32'd0) begin
            errors++; $display("FAIL rst_mid: irq=%b readdata=%h required 0/0", irq, readdata);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        bus_read(3'd0, d);
        checks++;
        if (d !== 32'h01) begin errors++; $display("FAIL rst_data: got %h required 01", d); end
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h00) begin errors++; $display("FAIL rst_cap: got %h required 00", d); end
        bus_write(3'd1, 32'h01);
        bus_write(3'd2, 32'h01);
        repeat (5) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rst_reenable_irq: got %b required 0", irq); end
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h00) begin errors++; $display("FAIL rst_reenable_cap: got %h required 00", d); end
    endtask

    initial begin
        test_reset();
        test_rise_default();
        test_w1c();
        test_fall();
        test_debounce();
        test_mask();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
